// File: rtl/naive_bus_uart_tx_if.sv
// naive_bus: split read/write request/grant bus between the router and its slaves.
// Slaves see addresses already masked to their own offset window.
interface naive_bus;
    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        output rd_gnt, rd_data, wr_gnt
    );
endinterface

// File: rtl/naive_bus_uart_tx.sv
// UART transmitter on naive_bus: TXDATA (0x0) feeds a byte FIFO, STATUS (0x4) reports FIFO/FSM state.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module naive_bus_uart_tx #(
    parameter int CLK_DIV         = 868,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    naive_bus.slave bus,
    output logic    tx
);
    localparam int               DEPTH      = 1 << FIFO_DEPTH_LOG2;
    localparam int               CW         = FIFO_DEPTH_LOG2 + 1;
    localparam logic [15:0]      BIT_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [CW-1:0]    FULL_COUNT = CW'(DEPTH);
    localparam logic [1:0]       OFF_TXDATA = 2'd0;
    localparam logic [1:0]       OFF_STATUS = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0]                 r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wrPtr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rdPtr;
    logic [CW-1:0]              r_count;
    state_t                     r_state;
    logic [15:0]                r_divCnt;
    logic [2:0]                 r_bitIdx;
    logic [7:0]                 r_shift;
    logic                       r_tx;
    logic [31:0]                r_rdData;
`ifdef UART_TX_PARITY_EN
    logic                       r_parity;
`endif

    logic        w_full;
    logic        w_empty;
    logic        w_wrTxData;
    logic        w_push;
    logic        w_pop;
    logic        w_bitDone;
    logic [7:0]  w_popData;
    logic [31:0] w_status;
    logic [31:0] w_rdValue;
    logic        w_unused;

    assign w_full     = (r_count == FULL_COUNT);
    assign w_empty    = (r_count == '0);
    assign w_wrTxData = bus.wr_req && (bus.wr_addr[3:2] == OFF_TXDATA) && bus.wr_be[0];
    // A write is refused whenever the FIFO is full, even if the FSM pops in the same cycle.
    assign w_push     = w_wrTxData && !w_full;
    assign w_bitDone  = (r_divCnt == 16'd0);
    assign w_pop      = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bitDone));
    assign w_popData  = r_mem[r_rdPtr];

    assign bus.rd_gnt  = 1'b1;
    assign bus.wr_gnt  = !(w_wrTxData && w_full);
    assign bus.rd_data = r_rdData;
    assign tx          = r_tx;

    assign w_unused = ^{bus.rd_addr[31:4], bus.rd_addr[1:0], bus.wr_addr[31:4],
                        bus.wr_addr[1:0], bus.wr_data[31:8], bus.wr_be[3:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wrPtr <= r_wrPtr + FIFO_DEPTH_LOG2'(1);
            if (w_pop)
                r_rdPtr <= r_rdPtr + FIFO_DEPTH_LOG2'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wrPtr] <= bus.wr_data[7:0];
    end

    // Every non-idle state holds for CLK_DIV cycles; the transition logic only runs on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_divCnt <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if ((r_state != S_IDLE) && !w_bitDone) begin
            r_divCnt <= r_divCnt - 16'd1;
        end else begin
            r_divCnt <= BIT_RELOAD;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= w_popData;
                        r_state  <= S_START;
                        r_tx     <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_popData;
`endif
                    end
                end
                S_START: begin
                    r_state  <= S_DATA;
                    r_bitIdx <= '0;
                    r_tx     <= r_shift[0];
                    r_shift  <= {1'b0, r_shift[7:1]};
                end
                S_DATA: begin
                    if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        r_state <= S_PARITY;
                        r_tx    <= r_parity;
`else
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
`endif
                    end else begin
                        r_bitIdx <= r_bitIdx + 3'd1;
                        r_tx     <= r_shift[0];
                        r_shift  <= {1'b0, r_shift[7:1]};
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    r_state <= S_STOP;
                    r_tx    <= 1'b1;
                end
`endif
                S_STOP: begin
                    // Chain straight into the next frame when another byte is waiting.
                    if (w_pop) begin
                        r_shift  <= w_popData;
                        r_state  <= S_START;
                        r_tx     <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_popData;
`endif
                    end else begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_status                     = '0;
        w_status[FIFO_DEPTH_LOG2:0]  = r_count;
        w_status[16]                 = (r_state != S_IDLE);
        w_status[17]                 = w_full;
        w_status[18]                 = w_empty;
    end

    assign w_rdValue = (bus.rd_addr[3:2] == OFF_STATUS) ? w_status : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rdData <= '0;
        else if (bus.rd_req)
            r_rdData <= w_rdValue;
    end
endmodule

// File: doc/naive_bus_uart_tx.md
NAIVE_BUS_UART_TX -- requirements
Module: naive_bus_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, meaning clk cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH_LOG2, default 4, meaning TX FIFO holds 2^FIFO_DEPTH_LOG2 bytes.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port bus  naive_bus.slave  -  bus port, one of the router's downstream slaves; addresses arrive already masked to slave offset.
REQ-006 SHALL have port tx  output  1  UART serial output, idle high.

Function
REQ-007 SHALL decode bus addresses on bits [3:2] only: 0x0 = TXDATA (write-only), 0x4 = STATUS (read-only); other offsets are reserved.
REQ-008 SHALL hold bus.rd_gnt at 1 every cycle.
REQ-009 SHALL register rd_data: when rd_req is granted in cycle N, rd_data carries the response in cycle N+1 and holds it until the next granted read.
REQ-010 SHALL return STATUS as: [FIFO_DEPTH_LOG2:0] fifo count, [16] busy (FSM not IDLE), [17] full, [18] empty, all other bits 0; reads of TXDATA/reserved return 0.
REQ-011 SHALL drive wr_gnt = 0 only when wr_req=1, offset=TXDATA, wr_be[0]=1 and FIFO full; otherwise wr_gnt = 1 (combinational).
REQ-012 SHALL enqueue wr_data[7:0] on a granted TXDATA write with wr_be[0]=1; granted writes with wr_be[0]=0 or to other offsets SHALL be ignored.
REQ-013 SHALL keep full-stall strict: a write while full is not granted even if a dequeue occurs the same cycle.
REQ-014 SHALL implement the FIFO with wrapping read/write pointers and a count 0..2^FIFO_DEPTH_LOG2; a simultaneous push and pop leaves count unchanged.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY (only per REQ-024), STOP; each non-IDLE state lasts exactly CLK_DIV cycles per bit, timed by a 16-bit down-counter.
REQ-016 SHALL, in IDLE with FIFO non-empty, pop one byte into a shift register and enter START next cycle; tx=0 in START.
REQ-017 SHALL send 8 DATA bits LSB first, then STOP with tx=1 for one bit time.
REQ-018 SHALL, at STOP end, pop and go directly to START if the FIFO is non-empty (no idle gap), else return to IDLE.
REQ-019 SHALL register tx (glitch-free); tx=1 in IDLE.

Reset
REQ-020 SHALL, on rst_n low, asynchronously set tx=1, FSM=IDLE, FIFO pointers and count=0, bit counter=0, rd_data=0.
REQ-021 SHALL abort any in-flight frame on reset mid-frame; no queued bytes survive reset.
REQ-022 SHALL not drive wr_gnt low during reset (FIFO empty).

Configuration
REQ-023 SHALL support macro UART_TX_PARITY_EN.
REQ-024 SHALL, with UART_TX_PARITY_EN defined, insert PARITY state between DATA and STOP sending even parity (XOR of 8 data bits), frame = 11 bit times; undefined: no PARITY state, frame = 10 bit times, parity logic absent.

Verification
REQ-025 CLK_DIV=4, write 0x55 to 0x0 -> tx: 4 cycles 0, then 1,0,1,0,1,0,1,0 at 4 cycles each, 4 cycles 1; frame 40 cycles (44 with parity bit 0).
REQ-026 Write 0x01,0x80 back-to-back -> second START begins the cycle after first STOP ends; busy=1 throughout; STATUS empty=1 after second pop.
REQ-027 FIFO_DEPTH_LOG2=4, 17 writes with tx blocked mid-frame -> first write popped, 16 queued, 18th write sees wr_gnt=0 until the frame ends; STATUS = count 16, full=1.
REQ-028 Read 0x4 in cycle N while idle -> rd_data=0x0004_0000 in cycle N+1; read 0x0 -> 0.
REQ-029 Write with wr_be=4'b1110 to 0x0 -> wr_gnt=1, count unchanged, tx stays 1.
REQ-030 Assert rst_n low during DATA bit 3 -> tx=1 immediately, STATUS after release = 0x0004_0000, no further frame output.
